// File: rtl/mm_seq.sv
// rtl/mm_seq.sv - block-transfer sequencer between register file and data RAM
module mm_seq #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int AW = 6
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic          op,
    input  logic [RW-1:0] reg_base,
    input  logic [AW-1:0] mem_base,
    input  logic [5:0]    count,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] R_Addr_A,
    output logic [RW-1:0] W_Addr,
    output logic [DW-1:0] W_Data,
    output logic          Write_reg,
    output logic          wea,
    output logic [AW-1:0] addr,
    input  logic [DW-1:0] douta
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t        r_state;
    logic [RW-1:0] r_rp;
    logic [AW-1:0] r_mp;
    logic [5:0]    r_rem;
    logic          r_vld1;
    logic [RW-1:0] r_wd_addr;
    logic          r_busy;
    logic          r_done;
    logic [RW-1:0] r_raddr;
    logic [RW-1:0] r_waddr;
    logic          r_wr;
    logic          r_wea;
    logic [AW-1:0] r_addr;

    // r_rem counts words still to issue after the one currently on the ports.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_rp      <= '0;
            r_mp      <= '0;
            r_rem     <= '0;
            r_vld1    <= 1'b0;
            r_wd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_raddr   <= '0;
            r_waddr   <= '0;
            r_wr      <= 1'b0;
            r_wea     <= 1'b0;
            r_addr    <= '0;
        end else begin
            r_done <= 1'b0;
            r_wea  <= 1'b0;
            r_wr   <= r_vld1;
            if (r_vld1) begin
                r_waddr <= r_wd_addr;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (count == 6'd0) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_busy <= 1'b1;
                            r_addr <= mem_base;
                            r_rp   <= reg_base + RW'(1);
                            r_mp   <= mem_base + AW'(1);
                            r_rem  <= count - 6'd1;
                            if (!op) begin
                                r_raddr <= reg_base;
                                r_wea   <= 1'b1;
                                r_state <= S_STORE;
                            end else begin
                                r_vld1    <= 1'b1;
                                r_wd_addr <= reg_base;
                                r_state   <= S_LOAD;
                            end
                        end
                    end
                end
                S_STORE: begin
                    if (r_rem == 6'd0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_raddr <= r_rp;
                        r_addr  <= r_mp;
                        r_wea   <= 1'b1;
                        r_rp    <= r_rp + RW'(1);
                        r_mp    <= r_mp + AW'(1);
                        r_rem   <= r_rem - 6'd1;
                    end
                end
                S_LOAD: begin
                    if (r_rem == 6'd0) begin
                        r_vld1  <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr    <= r_mp;
                        r_vld1    <= 1'b1;
                        r_wd_addr <= r_rp;
                        r_rp      <= r_rp + RW'(1);
                        r_mp      <= r_mp + AW'(1);
                        r_rem     <= r_rem - 6'd1;
                    end
                end
                S_DRAIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign R_Addr_A  = r_raddr;
    assign W_Addr    = r_waddr;
    assign Write_reg = r_wr;
    assign wea       = r_wea;
    assign addr      = r_addr;
    // RAM read data is already a register output; forward it only in write cycles.
    assign W_Data    = r_wr ? douta : '0;

endmodule

// File: tb/tb_mm_seq.sv
// tb/tb_mm_seq.sv - directed self-checking bench for mm_seq
module tb_mm_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        op;
    logic [4:0]  reg_base;
    logic [5:0]  mem_base;
    logic [5:0]  count;
    logic        busy;
    logic        done;
    logic [4:0]  R_Addr_A;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_reg;
    logic        wea;
    logic [5:0]  addr;
    logic [31:0] douta;
    logic [31:0] dina;

    logic [31:0] rf  [32];
    logic [31:0] ram [64];
    logic        pk_rf;
    logic        pk_ram;
    logic [5:0]  pk_idx;
    logic [31:0] pk_val;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mm_seq #(.DW(32), .RW(5), .AW(6)) dut (
        .Clk(clk), .Reset(rstn), .start(start), .op(op),
        .reg_base(reg_base), .mem_base(mem_base), .count(count),
        .busy(busy), .done(done), .R_Addr_A(R_Addr_A), .W_Addr(W_Addr),
        .W_Data(W_Data), .Write_reg(Write_reg), .wea(wea), .addr(addr),
        .douta(douta)
    );

    assign dina = rf[R_Addr_A];

    always @(posedge clk) begin
        if (pk_rf) rf[pk_idx[4:0]] <= pk_val;
        else if (Write_reg) rf[W_Addr] <= W_Data;
    end

    always @(posedge clk) begin
        if (pk_ram) ram[pk_idx] <= pk_val;
        else if (wea) ram[addr] <= dina;
        douta <= ram[addr];
    end

    task automatic poke_rf(input int i, input logic [31:0] v);
        pk_rf = 1'b1; pk_idx = 6'(i); pk_val = v;
        @(negedge clk);
        pk_rf = 1'b0;
    endtask

    task automatic poke_ram(input int i, input logic [31:0] v);
        pk_ram = 1'b1; pk_idx = 6'(i); pk_val = v;
        @(negedge clk);
        pk_ram = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of cycle T+1.
    task automatic issue(input logic o, input logic [4:0] rb, input logic [5:0] mb, input logic [5:0] c);
        op = o; reg_base = rb; mem_base = mb; count = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = ~o; reg_base = ~rb; mem_base = ~mb; count = 6'd63;
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({busy, done, wea, Write_reg, R_Addr_A, W_Addr, W_Data, addr} !== 52'd0) begin
            n_err++; $display("FAIL reset_outputs got b%0b d%0b we%0b wr%0b ra%0d wa%0d wd%h a%0d want all 0",
                busy, done, wea, Write_reg, R_Addr_A, W_Addr, W_Data, addr);
        end
        rstn = 1'b1;
        @(negedge clk);
        poke_ram(33, 32'hDEAD);
        poke_rf(2, 32'h5A);
        issue(1'b0, 5'd0, 6'd30, 6'd10);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, wea, Write_reg} !== 4'b0000) begin
            n_err++; $display("FAIL reset_mid_store flags got %b want 0000", {busy, done, wea, Write_reg});
        end
        n_cmp++;
        if ({R_Addr_A, addr} !== 11'd0) begin
            n_err++; $display("FAIL reset_mid_store addrs got ra%0d a%0d want 0 0", R_Addr_A, addr);
        end
        @(negedge clk);
        rstn = 1'b1;
        begin
            int we_n = 0, dn_n = 0;
            for (int k = 0; k < 12; k++) begin
                if (wea) we_n++;
                if (done) dn_n++;
                @(negedge clk);
            end
            n_cmp++;
            if (we_n !== 0 || dn_n !== 0) begin
                n_err++; $display("FAIL reset_after wea=%0d done=%0d want 0 0", we_n, dn_n);
            end
        end
        n_cmp++;
        if (ram[33] !== 32'hDEAD || ram[32] !== 32'h5A) begin
            n_err++; $display("FAIL reset_ram got ram32=%h ram33=%h want 5a dead", ram[32], ram[33]);
        end
    endtask

    task automatic test_store;
        for (int i = 0; i < 4; i++) poke_rf(4 + i, 32'h11 * (i + 1));
        issue(1'b0, 5'd4, 6'd8, 6'd4);
        for (int k = 1; k <= 6; k++) begin
            n_cmp++;
            if ({busy, done, wea, Write_reg} !== {k <= 4, k == 5, k <= 4, 1'b0}) begin
                n_err++; $display("FAIL store_flags k=%0d got %b want %b", k,
                    {busy, done, wea, Write_reg}, {k <= 4, k == 5, k <= 4, 1'b0});
            end
            if (k <= 4) begin
                n_cmp++;
                if (R_Addr_A !== 5'(3 + k) || addr !== 6'(7 + k)) begin
                    n_err++; $display("FAIL store_addr k=%0d got ra%0d a%0d want ra%0d a%0d",
                        k, R_Addr_A, addr, 3 + k, 7 + k);
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ram[8 + i] !== 32'h11 * (i + 1)) begin
                n_err++; $display("FAIL store_ram[%0d] got %h want %h", 8 + i, ram[8 + i], 32'h11 * (i + 1));
            end
        end
    endtask

    task automatic test_load;
        poke_ram(20, 32'hA0); poke_ram(21, 32'hB0); poke_ram(22, 32'hC0);
        issue(1'b1, 5'd10, 6'd20, 6'd3);
        for (int k = 1; k <= 6; k++) begin
            n_cmp++;
            if ({busy, done, wea, Write_reg} !== {k <= 4, k == 5, 1'b0, k >= 2 && k <= 4}) begin
                n_err++; $display("FAIL load_flags k=%0d got %b want %b", k,
                    {busy, done, wea, Write_reg}, {k <= 4, k == 5, 1'b0, k >= 2 && k <= 4});
            end
            if (k <= 3) begin
                n_cmp++;
                if (addr !== 6'(19 + k)) begin
                    n_err++; $display("FAIL load_addr k=%0d got %0d want %0d", k, addr, 19 + k);
                end
            end
            if (k >= 2 && k <= 4) begin
                n_cmp++;
                if (W_Addr !== 5'(8 + k) || W_Data !== 32'hA0 + 32'h10 * (k - 2)) begin
                    n_err++; $display("FAIL load_wb k=%0d got wa%0d wd%h want wa%0d wd%h",
                        k, W_Addr, W_Data, 8 + k, 32'hA0 + 32'h10 * (k - 2));
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (rf[10] !== 32'hA0 || rf[11] !== 32'hB0 || rf[12] !== 32'hC0) begin
            n_err++; $display("FAIL load_rf got %h %h %h want a0 b0 c0", rf[10], rf[11], rf[12]);
        end
    endtask

    task automatic test_wrap;
        logic [4:0] exp_r [4];
        logic [5:0] exp_a [4];
        exp_r = '{5'd30, 5'd31, 5'd0, 5'd1};
        exp_a = '{6'd62, 6'd63, 6'd0, 6'd1};
        for (int i = 0; i < 4; i++) poke_rf(int'(exp_r[i]), 32'h300 + i);
        issue(1'b0, 5'd30, 6'd62, 6'd4);
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) begin
                n_cmp++;
                if (wea !== 1'b1 || R_Addr_A !== exp_r[k - 1] || addr !== exp_a[k - 1]) begin
                    n_err++; $display("FAIL wrap k=%0d got we%0b ra%0d a%0d want we1 ra%0d a%0d",
                        k, wea, R_Addr_A, addr, exp_r[k - 1], exp_a[k - 1]);
                end
            end else begin
                n_cmp++;
                if ({done, wea} !== 2'b10) begin
                    n_err++; $display("FAIL wrap_done got d%0b we%0b want d1 we0", done, wea);
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ram[exp_a[i]] !== 32'h300 + i) begin
                n_err++; $display("FAIL wrap_ram[%0d] got %h want %h", exp_a[i], ram[exp_a[i]], 32'h300 + i);
            end
        end
    endtask

    task automatic test_zero_ignore;
        int wr_n = 0, dn_n = 0, we_n = 0;
        issue(1'b0, 5'd7, 6'd7, 6'd0);
        n_cmp++;
        if ({busy, done, wea, Write_reg} !== 4'b0100) begin
            n_err++; $display("FAIL zero_t1 got %b want 0100", {busy, done, wea, Write_reg});
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done, wea, Write_reg} !== 4'b0000) begin
            n_err++; $display("FAIL zero_t2 got %b want 0000", {busy, done, wea, Write_reg});
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) poke_ram(40 + i, 32'h100 + i);
        issue(1'b1, 5'd16, 6'd40, 6'd5);
        for (int k = 1; k <= 10; k++) begin
            if (Write_reg) wr_n++;
            if (done) dn_n++;
            if (wea) we_n++;
            start = 1'b0;
            if (k == 2) begin
                op = 1'b0; reg_base = 5'd0; mem_base = 6'd0; count = 6'd3; start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (wr_n !== 5 || dn_n !== 1 || we_n !== 0) begin
            n_err++; $display("FAIL ignore got wr=%0d done=%0d wea=%0d want 5 1 0", wr_n, dn_n, we_n);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rf[16 + i] !== 32'h100 + i) begin
                n_err++; $display("FAIL ignore_rf[%0d] got %h want %h", 16 + i, rf[16 + i], 32'h100 + i);
            end
        end
    endtask

    task automatic test_back_to_back;
        int dn_n = 0;
        poke_rf(2, 32'hCAFE0002);
        poke_rf(3, 32'hCAFE0003);
        issue(1'b0, 5'd2, 6'd50, 6'd2);
        for (int k = 1; k <= 3; k++) begin
            if (done) dn_n++;
            @(negedge clk);
        end
        issue(1'b1, 5'd24, 6'd50, 6'd2);
        for (int k = 1; k <= 6; k++) begin
            if (done) dn_n++;
            if (k == 4) begin
                n_cmp++;
                if (done !== 1'b1) begin
                    n_err++; $display("FAIL b2b_load_done got %0b want 1", done);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (dn_n !== 2) begin
            n_err++; $display("FAIL b2b_done_count got %0d want 2", dn_n);
        end
        n_cmp++;
        if (rf[24] !== 32'hCAFE0002 || rf[25] !== 32'hCAFE0003) begin
            n_err++; $display("FAIL b2b_rf got %h %h want cafe0002 cafe0003", rf[24], rf[25]);
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; op = 1'b0;
        reg_base = '0; mem_base = '0; count = '0;
        pk_rf = 1'b0; pk_ram = 1'b0; pk_idx = '0; pk_val = '0;
        repeat (3) @(negedge clk);
        test_reset;
        test_store;
        test_load;
        test_wrap;
        test_zero_ignore;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
